// File: rtl/vfm_core_mailbox_if.sv
// Send/receive channels between the cores and the mailbox, one flat slice per core.
interface vfm_core_mailbox_if #(
   parameter int NCORES = 4,
   parameter int WIDTH  = 14,
   parameter int DEPTH  = 4
);
   localparam int DW = (NCORES <= 2) ? 1 : $clog2(NCORES);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NCORES-1:0]       tx_valid;
   logic [NCORES*DW-1:0]    tx_dest;
   logic [NCORES*WIDTH-1:0] tx_data;
   logic [NCORES-1:0]       tx_ready;
   logic [NCORES-1:0]       rx_valid;
   logic [NCORES*WIDTH-1:0] rx_data;
   logic [NCORES-1:0]       rx_pop;
   logic [NCORES*CW-1:0]    rx_count;
   logic                    drop_err;

   modport master (
      output tx_valid, tx_dest, tx_data, rx_pop,
      input  tx_ready, rx_valid, rx_data, rx_count, drop_err
   );

   modport slave (
      input  tx_valid, tx_dest, tx_data, rx_pop,
      output tx_ready, rx_valid, rx_data, rx_count, drop_err
   );
endinterface

// File: rtl/vfm_core_mailbox.sv
// Inter-core mailbox: per-destination round-robin arbiter feeding a show-ahead FIFO.
module vfm_core_mailbox #(
   parameter int NCORES = 4,
   parameter int WIDTH  = 14,
   parameter int DEPTH  = 4
) (
   input  logic              Clock_pin,
   input  logic              Resetn_pin,
   vfm_core_mailbox_if.slave mb
);
   localparam int DW = (NCORES <= 2) ? 1 : $clog2(NCORES);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [DW-1:0]    dest_t;
   typedef logic [AW-1:0]    ptr_t;
   typedef logic [CW-1:0]    cnt_t;

   word_t mem_q [NCORES][DEPTH];
   ptr_t  rd_ptr_q [NCORES], rd_ptr_d [NCORES];
   ptr_t  wr_ptr_q [NCORES], wr_ptr_d [NCORES];
   cnt_t  count_q  [NCORES], count_d  [NCORES];
   dest_t rr_q     [NCORES], rr_d     [NCORES];
   word_t last_q   [NCORES], last_d   [NCORES];
   logic  drop_q, drop_d;

   dest_t             dest     [NCORES];
   word_t             din      [NCORES];
   dest_t             push_src [NCORES];
   logic [NCORES-1:0] push, pop, ready;

   always_comb begin
      for (int s = 0; s < NCORES; s++) begin
         dest[s] = mb.tx_dest[s*DW +: DW];
         din[s]  = mb.tx_data[s*WIDTH +: WIDTH];
      end
   end

   // Arbitration uses the registered count, so a same-cycle pop never frees a slot.
   always_comb begin
      int   src;
      logic found;
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      ready  = '0;
      push   = '0;
      drop_d = drop_q;
      src    = 0;
      found  = 1'b0;
      for (int d = 0; d < NCORES; d++) push_src[d] = '0;
      if (Resetn_pin) begin
         for (int s = 0; s < NCORES; s++) begin
            if (mb.tx_valid[s] && int'(dest[s]) >= NCORES) begin
               ready[s] = 1'b1;
               drop_d   = 1'b1;
            end
         end
         for (int d = 0; d < NCORES; d++) begin
            found = 1'b0;
            for (int i = 0; i < NCORES; i++) begin
               src = int'(rr_q[d]) + i;
               if (src >= NCORES) src = src - NCORES;
               if (!found && mb.tx_valid[src] && int'(dest[src]) == d) begin
                  found       = 1'b1;
                  push_src[d] = dest_t'(src);
                  if (count_q[d] < cnt_t'(DEPTH)) begin
                     ready[src] = 1'b1;
                     push[d]    = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      int nxt;
      nxt = 0;
      for (int d = 0; d < NCORES; d++) begin
         pop[d]      = mb.rx_pop[d] && (count_q[d] != '0);
         count_d[d]  = count_q[d] + cnt_t'(push[d]) - cnt_t'(pop[d]);
         wr_ptr_d[d] = push[d] ? wr_ptr_q[d] + ptr_t'(1) : wr_ptr_q[d];
         rd_ptr_d[d] = pop[d]  ? rd_ptr_q[d] + ptr_t'(1) : rd_ptr_q[d];
         last_d[d]   = pop[d]  ? mem_q[d][rd_ptr_q[d]]  : last_q[d];
         nxt = int'(push_src[d]) + 1;
         if (nxt == NCORES) nxt = 0;
         rr_d[d] = push[d] ? dest_t'(nxt) : rr_q[d];
      end
   end

   always_ff @(posedge Clock_pin) begin
      // NOTE: sequential state uses <= so every register updates from pre-edge values.
      if (!Resetn_pin) begin
         for (int d = 0; d < NCORES; d++) begin
            rd_ptr_q[d] <= '0;
            wr_ptr_q[d] <= '0;
            count_q[d]  <= '0;
            rr_q[d]     <= '0;
            last_q[d]   <= '0;
         end
         drop_q <= 1'b0;
      end else begin
         for (int d = 0; d < NCORES; d++) begin
            rd_ptr_q[d] <= rd_ptr_d[d];
            wr_ptr_q[d] <= wr_ptr_d[d];
            count_q[d]  <= count_d[d];
            rr_q[d]     <= rr_d[d];
            last_q[d]   <= last_d[d];
         end
         drop_q <= drop_d;
      end
   end

   // NOTE: FIFO storage is not reset; count gating hides stale entries and last_q covers empty reads.
   always_ff @(posedge Clock_pin) begin
      for (int d = 0; d < NCORES; d++) begin
         if (push[d]) mem_q[d][wr_ptr_q[d]] <= din[push_src[d]];
      end
   end

   always_comb begin
      mb.tx_ready = ready;
      mb.drop_err = drop_q;
      mb.rx_valid = '0;
      mb.rx_data  = '0;
      mb.rx_count = '0;
      for (int d = 0; d < NCORES; d++) begin
         mb.rx_valid[d]               = (count_q[d] != '0);
         mb.rx_data[d*WIDTH +: WIDTH] = (count_q[d] != '0) ? mem_q[d][rd_ptr_q[d]] : last_q[d];
         mb.rx_count[d*CW +: CW]      = count_q[d];
      end
   end
endmodule

// File: doc/vfm_core_mailbox.md
Name: vfm_core_mailbox

Overview:
- Parametrised inter-core message fabric for the multicore vfmRISC621pipe_v top level.
- Replaces hardwired per-pair ack/data port wiring with one mailbox block.
- Each core may send WIDTH-bit words to any core, including itself, using a valid/ready handshake.
- Each destination has a DEPTH-entry show-ahead FIFO, fed by a round-robin arbiter across all sources.

Parameters:
- NCORES, 4, number of cores; legal range 2..8.
- WIDTH, 14, message word width; matches the core In/Out port width.
- DEPTH, 4, entries per destination FIFO; power of 2, at least 2.
- DW, derived as max(1, clog2(NCORES)), width of a destination ID.

Ports:
- Clock_pin  in  1  system clock; all state updates on its rising edge.
- Resetn_pin  in  1  reset; synchronous, active-low.
- tx_valid  in  NCORES  bit s: source s offers a word.
- tx_dest  in  NCORES*DW  slice s: destination ID for source s.
- tx_data  in  NCORES*WIDTH  slice s: word from source s.
- tx_ready  out  NCORES  bit s: word from source s accepted this cycle; combinational.
- rx_valid  out  NCORES  bit d: FIFO d is non-empty.
- rx_data  out  NCORES*WIDTH  slice d: head word of FIFO d.
- rx_pop  in  NCORES  bit d: consume the head of FIFO d.
- rx_count  out  NCORES*(clog2(DEPTH)+1)  slice d: occupancy of FIFO d.
- drop_err  out  1  sticky flag: a word was sent to a nonexistent core.

Behaviour:
- Reset (Resetn_pin low at a rising edge):
  - All FIFOs empty; rx_count = 0; rx_valid = 0; rx_data = 0.
  - All RR pointers = 0; drop_err = 0.
  - Words offered during the reset cycle are not accepted; tx_ready = 0 while Resetn_pin is low.
  - A reset mid-operation discards all buffered words.
- Handshake:
  - A transfer from source s occurs when tx_valid[s] and tx_ready[s] are both high at a rising edge.
  - Sources hold tx_data and tx_dest stable until accepted.
- Arbitration, per destination d:
  - Requesters: sources with tx_valid high and tx_dest = d.
  - Grant goes to the first requester at or after ptr[d], searching upward with wrap at NCORES.
  - On an accepted transfer, ptr[d] becomes (granted source + 1) mod NCORES.
  - ptr[d] is unchanged when no transfer to d occurs.
- Acceptance:
  - tx_ready[s] = granted[s] AND (count[d] < DEPTH).
  - Full check uses the registered count; a pop in the same cycle does NOT free a slot for that cycle.
- Invalid destination (tx_dest >= NCORES, only possible when NCORES is not a power of 2):
  - tx_ready[s] = 1 and the word is discarded.
  - drop_err is set at that edge and stays set until reset.
- Concurrency:
  - Different destinations accept in parallel, up to NCORES words per cycle total.
  - Each source sends at most one word per cycle.
- FIFO behaviour:
  - Push and pop are independent.
  - Latency: a word accepted at edge k appears on rx_data/rx_valid after edge k. When the FIFO is empty it becomes the head immediately.
  - Pop with rx_valid = 0 is ignored; count does not underflow.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged, head advances.
  - Read/write pointers wrap modulo DEPTH.
  - Ordering: FIFO per destination; words from one source to one destination stay in order.
- rx_data when empty:
  - Holds the last popped value.
  - Not meaningful unless rx_valid = 1.

Test Plan:
- Reset: drive tx_valid = 1111 during reset -> tx_ready = 0000; after release rx_valid = 0000, rx_count all 0, drop_err = 0.
- Single transfer: s1 sends 14'h0155 to d0 -> tx_ready[1] = 1 that cycle. Next cycle rx_valid[0] = 1, rx_data[0] = 14'h0155, rx_count[0] = 1. Pulse rx_pop[0] -> rx_valid[0] = 0 the following cycle.
- Contention and fairness: s1, s2, s3 hold valid to d0 with data 0x011, 0x022, 0x033, refilling after each accept, 6 cycles with d0 popped every cycle -> accepts in order s1, s2, s3, s1, s2, s3; rx_data[0] shows the same order.
- Full boundary: DEPTH = 4, s2 sends 0x001..0x005 to d3 with no pops -> first 4 accepted, rx_count[3] = 4, tx_ready[2] = 0 for 0x005. Pop in cycle t -> 0x005 accepted at cycle t+1, not at t.
- Parallel and loopback: in the same cycle s0->d1 0x0AA, s1->d0 0x0BB, s2->d2 0x0CC -> all three tx_ready high; each destination shows its word next cycle.
- Invalid destination: NCORES = 3, s0 sends tx_dest = 3 -> tx_ready[0] = 1, drop_err = 1 next cycle and it stays set. No rx_valid is asserted; drop_err clears only on reset.
